// File: rtl/sd_pkg.sv
// Shared constants for the SD data-line transfer sequencer:
// state encoding, error codes and the default CRC retry budget.
package sd_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_RCV_GO    = 4'd1;
  localparam logic [3:0] S_RCV_WAIT  = 4'd2;
  localparam logic [3:0] S_PROC_GO   = 4'd3;
  localparam logic [3:0] S_PROC_WAIT = 4'd4;
  localparam logic [3:0] S_SEND_GO   = 4'd5;
  localparam logic [3:0] S_SEND_WAIT = 4'd6;
  localparam logic [3:0] S_NEXT      = 4'd7;
  localparam logic [3:0] S_FIN       = 4'd8;
  localparam logic [3:0] S_ERR       = 4'd9;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CRC  = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;

  localparam int MAX_RETRY_DEF = 3;

endpackage

// File: rtl/wait_tmr.sv
// Wait-state watchdog: counts enabled cycles, saturates at all-ones and flags it.
// Clear wins over enable; the flag is a decode of the registered count.
module wait_tmr #(
  parameter int TMO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic full
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !full) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign full = &cnt;

endmodule

// File: rtl/d_seq.sv
// Multi-block receive -> cipher -> send sequencer for the 4-bit D-line driver.
// All outputs registered from the next state, so each pulse appears the cycle its state is entered.
module d_seq
  import sd_pkg::*;
#(
  parameter int BLK_W     = 8,
  parameter int MAX_RETRY = MAX_RETRY_DEF,
  parameter int TMO_W     = 20
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             istart,
  input  logic [BLK_W-1:0] iblk_cnt,
  output logic             ostart_d,
  input  logic             id_done,
  input  logic             id_crc_fail,
  output logic             ostart_proc,
  input  logic             iproc_done,
  output logic             obusy,
  output logic             odone,
  output logic             oerr,
  output logic [1:0]       oerr_code,
  output logic [BLK_W-1:0] oblk_idx
);

  localparam int RTR_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RTR_W-1:0] RTR_MAX = RTR_W'(MAX_RETRY);

  logic [3:0]       state, nstate;
  logic [BLK_W-1:0] blk_cnt;
  logic [RTR_W-1:0] retry;
  logic             armed, tmo, in_wait, d_wait, rcv_ok, rcv_bad, last_blk;
  logic             start_d_n, start_proc_n, busy_n, done_n;

  assign d_wait   = (state == S_RCV_WAIT) || (state == S_SEND_WAIT);
  assign in_wait  = d_wait || (state == S_PROC_WAIT);
  assign rcv_ok   = armed && id_done && !id_crc_fail;
  assign rcv_bad  = armed && id_done && id_crc_fail;
  assign last_blk = (oblk_idx == blk_cnt - BLK_W'(1));

  wait_tmr #(.TMO_W(TMO_W)) u_tmr (
    .clk  (iclk),
    .rst  (irst),
    .en   (in_wait),
    .clr  (nstate != state),
    .full (tmo)
  );

  always_ff @(posedge iclk) begin
    if (irst) state <= S_IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:      if (istart && (iblk_cnt != '0)) nstate = S_RCV_GO;
      S_RCV_GO:    nstate = S_RCV_WAIT;
      S_RCV_WAIT: begin
        if (tmo)          nstate = S_ERR;
        else if (rcv_ok)  nstate = S_PROC_GO;
        else if (rcv_bad) nstate = (retry < RTR_MAX) ? S_RCV_GO : S_ERR;
      end
      S_PROC_GO:   nstate = S_PROC_WAIT;
      S_PROC_WAIT: begin
        if (tmo)             nstate = S_ERR;
        else if (iproc_done) nstate = S_SEND_GO;
      end
      S_SEND_GO:   nstate = S_SEND_WAIT;
      S_SEND_WAIT: begin
        if (tmo)                   nstate = S_ERR;
        else if (armed && id_done) nstate = S_NEXT;
      end
      S_NEXT:      nstate = last_blk ? S_FIN : S_RCV_GO;
      S_FIN:       nstate = S_IDLE;
      S_ERR:       nstate = S_IDLE;
      default:     nstate = S_IDLE;
    endcase
  end

  always_comb begin
    start_d_n    = (nstate == S_RCV_GO) || (nstate == S_SEND_GO);
    start_proc_n = (nstate == S_PROC_GO);
    busy_n       = (nstate != S_IDLE);
    done_n       = (nstate == S_FIN) || (nstate == S_ERR) ||
                   ((state == S_IDLE) && istart && (iblk_cnt == '0));
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      blk_cnt     <= '0;
      retry       <= '0;
      armed       <= 1'b0;
      ostart_d    <= 1'b0;
      ostart_proc <= 1'b0;
      obusy       <= 1'b0;
      odone       <= 1'b0;
      oerr        <= 1'b0;
      oerr_code   <= ERR_NONE;
      oblk_idx    <= '0;
    end else begin
      ostart_d    <= start_d_n;
      ostart_proc <= start_proc_n;
      obusy       <= busy_n;
      odone       <= done_n;
      if ((state == S_IDLE) && istart) begin
        oerr      <= 1'b0;
        oerr_code <= ERR_NONE;
        if (iblk_cnt != '0) begin
          blk_cnt  <= iblk_cnt;
          oblk_idx <= '0;
          retry    <= '0;
        end
      end
      // The driver keeps id_done high until it registers our pulse, so wait to see it drop.
      if ((state == S_RCV_GO) || (state == S_SEND_GO)) armed <= 1'b0;
      else if (d_wait)                                 armed <= armed | ~id_done;
      if ((state == S_RCV_WAIT) && (nstate == S_RCV_GO)) retry <= retry + RTR_W'(1);
      if ((state == S_NEXT) && (nstate == S_RCV_GO)) begin
        oblk_idx <= oblk_idx + BLK_W'(1);
        retry    <= '0;
      end
      if (nstate == S_ERR) begin
        oerr      <= 1'b1;
        oerr_code <= tmo ? ERR_TMO : ERR_CRC;
      end
    end
  end

endmodule

// File: tb/tb_d_seq.sv
// Bench for d_seq: reactive driver/cipher models, table vectors, hand-written reset sequence
// and randomized runs checked against a phase-duration reference model.
module tb_d_seq;

  localparam int MAX_RETRY = 3;
  localparam int TMO_W     = 6;

  logic       iclk = 1'b0;
  logic       irst, istart, id_done, id_crc_fail, iproc_done;
  logic [7:0] iblk_cnt, oblk_idx;
  logic       ostart_d, ostart_proc, obusy, odone, oerr;
  logic [1:0] oerr_code;

  d_seq #(.BLK_W(8), .MAX_RETRY(MAX_RETRY), .TMO_W(TMO_W)) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iblk_cnt(iblk_cnt),
    .ostart_d(ostart_d), .id_done(id_done), .id_crc_fail(id_crc_fail),
    .ostart_proc(ostart_proc), .iproc_done(iproc_done), .obusy(obusy),
    .odone(odone), .oerr(oerr), .oerr_code(oerr_code), .oblk_idx(oblk_idx)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    int n; logic [15:0] f; int d; int l; int p; int poke;
    int nd; int np; logic err; logic [1:0] code; int done; int idx;
    string nm;
  } vec_t;

  vec_t tbl[8];
  vec_t rv, mv;

  int vectors = 0;
  int miscompares = 0;

  // driver / cipher model state and per-run observations
  int g_d, g_l, g_p;
  logic [15:0] g_f;
  int rcv_i, drv_t, pr_t, cyc;
  logic drv_act, drv_rcv, pr_act;
  int s_nd, s_np, s_ndone, s_busy, s_done_cyc;
  logic s_err;
  logic [1:0] s_code;
  logic [7:0] s_idx;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Expected result from phase durations: a driver job occupies d+l+1 cycles from its start
  // pulse, cipher p+1 cycles, each block ends with one NEXT cycle; first start pulse is cycle 1.
  task automatic model(input vec_t vi, output vec_t vo);
    int t, rcv, tries, job;
    logic fl;
    vo = vi;
    vo.nd = 0; vo.np = 0; vo.err = 1'b0; vo.code = 2'b00; vo.idx = 0;
    job = vi.d + vi.l + 1;
    t = 1; rcv = 0;
    if (vi.n == 0) begin
      vo.done = 1;
      return;
    end
    for (int b = 0; b < vi.n; b++) begin
      vo.idx = b;
      tries = 0;
      do begin
        vo.nd++;
        t += job;
        fl = (rcv < 16) && vi.f[rcv];
        rcv++;
        if (fl) begin
          if (tries == MAX_RETRY) begin
            vo.err = 1'b1; vo.code = 2'b01; vo.done = t;
            return;
          end
          tries++;
        end
      end while (fl);
      vo.np++;
      if (vi.p < 0) begin
        vo.err = 1'b1; vo.code = 2'b10; vo.done = t + 1 + (1 << TMO_W);
        return;
      end
      t += vi.p + 1;
      vo.nd++;
      t += job + 1;
    end
    vo.done = t;
  endtask

  task automatic step();
    logic fb;
    @(negedge iclk);
    cyc++;
    iproc_done = 1'b0;
    if (ostart_d) s_nd++;
    if (ostart_proc) s_np++;
    if (obusy) s_busy++;
    if (odone) begin
      s_ndone++;
      if (s_done_cyc < 0) begin
        s_done_cyc = cyc; s_err = oerr; s_code = oerr_code; s_idx = oblk_idx;
      end
    end
    if (drv_act) begin
      drv_t++;
      if (drv_t == g_d) id_done = 1'b0;
      if (drv_t == g_d + g_l) begin
        id_done = 1'b1;
        drv_act = 1'b0;
        if (drv_rcv) begin
          fb = (rcv_i < 16) && g_f[rcv_i];
          rcv_i++;
          id_crc_fail = fb;
          drv_rcv = fb;  // a good receive parks the driver ready to send
        end else begin
          id_crc_fail = 1'b0;
          drv_rcv = 1'b1;
        end
      end
    end
    if (ostart_d) begin drv_act = 1'b1; drv_t = 0; end
    if (pr_act) begin
      pr_t++;
      if (pr_t == g_p) begin iproc_done = 1'b1; pr_act = 1'b0; end
    end
    if (ostart_proc && g_p >= 0) begin pr_act = 1'b1; pr_t = 0; end
  endtask

  task automatic start_run(input vec_t v);
    g_d = v.d; g_l = v.l; g_p = v.p; g_f = v.f;
    rcv_i = 0; drv_rcv = 1'b1; drv_act = 1'b0; pr_act = 1'b0;
    id_done = 1'b1; id_crc_fail = 1'b0;
    s_nd = 0; s_np = 0; s_ndone = 0; s_busy = 0; s_done_cyc = -1;
    s_err = 1'b0; s_code = 2'b00; s_idx = '0;
    cyc = 0;
    istart = 1'b1;
    iblk_cnt = 8'(v.n);
  endtask

  task automatic run_case(input vec_t v);
    start_run(v);
    for (int k = 0; k < v.done + 200; k++) begin
      step();
      istart = 1'b0;
      if (v.poke > 0 && cyc == v.poke) begin
        istart = 1'b1;
        iblk_cnt = 8'(v.n + 3);
      end
      if (s_done_cyc >= 0 && cyc >= s_done_cyc + 3 && !drv_act) break;
    end
    istart = 1'b0;
    chk({v.nm, ".done_cycle"}, s_done_cyc, v.done);
    chk({v.nm, ".done_pulses"}, s_ndone, 1);
    chk({v.nm, ".start_d_pulses"}, s_nd, v.nd);
    chk({v.nm, ".start_proc_pulses"}, s_np, v.np);
    chk({v.nm, ".err"}, int'(s_err), int'(v.err));
    chk({v.nm, ".err_code"}, int'(s_code), int'(v.code));
    if (v.n > 0) chk({v.nm, ".blk_idx"}, int'(s_idx), v.idx);
    else         chk({v.nm, ".busy_cycles"}, s_busy, 0);
    chk({v.nm, ".err_held"}, int'(oerr), int'(v.err));
    chk({v.nm, ".idle_busy"}, int'(obusy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n:2, f:16'h0, d:3, l:40, p:10, poke:30, nd:4, np:2, err:1'b0, code:2'b00, done:201, idx:1, nm:"two_blk"};
    tbl[1] = '{n:1, f:16'hF, d:3, l:40, p:10, poke:0, nd:4, np:0, err:1'b1, code:2'b01, done:177, idx:0, nm:"crc_exhaust"};
    tbl[2] = '{n:1, f:16'h3, d:3, l:40, p:10, poke:0, nd:4, np:1, err:1'b0, code:2'b00, done:189, idx:0, nm:"crc_retry2"};
    tbl[3] = '{n:1, f:16'h7, d:3, l:40, p:10, poke:0, nd:5, np:1, err:1'b0, code:2'b00, done:233, idx:0, nm:"crc_retry3"};
    tbl[4] = '{n:1, f:16'h0, d:3, l:40, p:-1, poke:0, nd:1, np:1, err:1'b1, code:2'b10, done:110, idx:0, nm:"proc_tmo"};
    tbl[5] = '{n:1, f:16'h0, d:3, l:70, p:10, poke:0, nd:1, np:0, err:1'b1, code:2'b10, done:66, idx:0, nm:"rcv_tmo"};
    tbl[6] = '{n:0, f:16'h0, d:3, l:40, p:10, poke:0, nd:0, np:0, err:1'b0, code:2'b00, done:1, idx:0, nm:"zero_blk"};
    tbl[7] = '{n:255, f:16'h0, d:1, l:2, p:1, poke:0, nd:510, np:255, err:1'b0, code:2'b00, done:2806, idx:254, nm:"blk255"};

    irst = 1'b1; istart = 1'b0; iblk_cnt = '0;
    id_done = 1'b1; id_crc_fail = 1'b0; iproc_done = 1'b0;
    drv_act = 1'b0; pr_act = 1'b0; drv_rcv = 1'b1;
    g_d = 3; g_l = 40; g_p = 10; g_f = '0; rcv_i = 0; cyc = 0;
    repeat (3) @(negedge iclk);
    chk("reset_outputs", int'({ostart_d, ostart_proc, obusy, odone, oerr, oerr_code, oblk_idx}), 0);
    irst = 1'b0;

    for (int i = 0; i < 8; i++) run_case(tbl[i]);

    // reset while the driver is sending block 0
    rv = '{n:2, f:16'h0, d:3, l:40, p:10, poke:0, nd:0, np:0, err:1'b0, code:2'b00, done:0, idx:0, nm:"rst_mid"};
    start_run(rv);
    repeat (70) begin step(); istart = 1'b0; end
    chk("rst_mid.busy_before", int'(obusy), 1);
    irst = 1'b1;
    step();
    chk("rst_mid.outputs", int'({ostart_d, ostart_proc, obusy, odone, oerr, oerr_code, oblk_idx}), 0);
    irst = 1'b0;
    drv_act = 1'b0; id_done = 1'b1; id_crc_fail = 1'b0;
    s_ndone = 0; s_busy = 0;
    repeat (5) step();
    chk("rst_mid.no_done", s_ndone, 0);
    chk("rst_mid.idle_busy", s_busy, 0);
    rv.n = 1; rv.nm = "after_rst";
    model(rv, mv);
    run_case(mv);

    for (int r = 0; r < 30; r++) begin
      rv.n = int'($urandom_range(3, 1));
      rv.f = 16'($urandom & $urandom & $urandom);
      rv.d = int'($urandom_range(4, 1));
      rv.l = int'($urandom_range(30, 4));
      rv.p = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(12, 1));
      rv.nm = $sformatf("rand%0d", r);
      model(rv, mv);
      mv.poke = ($urandom_range(1, 0) == 1) ? int'($urandom_range(mv.done, 2)) : 0;
      run_case(mv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_seq.md
Name: d_seq

Overview:
- Transfer sequencer for the 4-bit D-line driver.
- Runs a multi-block read → process → write-back loop. For each block it:
  - pulses the driver to receive,
  - checks CRC status and retries on failure,
  - hands the block RAM to the cipher core,
  - pulses the driver to send, then waits for card busy to release.
- Sits between the SD command-layer FSM above and the D-line driver / cipher core below.

Parameters:
- BLK_W, 8, width of block count and block index
- MAX_RETRY, 3, CRC-fail re-receive attempts per block before error
- TMO_W, 20, timeout counter width; timeout fires at all-ones (2^TMO_W-1 cycles) in any wait state

Ports:
- iclk  in  1  SD clock, sole clock
- irst  in  1  synchronous, active-high reset
- istart  in  1  start request from command layer; sampled only in S_IDLE
- iblk_cnt  in  BLK_W  number of blocks to process; latched on accepted istart
- ostart_d  out  1  one-cycle start pulse to D-line driver
- id_done  in  1  driver done level (high when driver idle or waiting to send)
- id_crc_fail  in  1  driver CRC-fail flag, valid when id_done high after a receive
- ostart_proc  out  1  one-cycle start pulse to cipher core
- iproc_done  in  1  cipher core done pulse or level; first high after ostart_proc counts
- obusy  out  1  high in every state except S_IDLE
- odone  out  1  one-cycle pulse at end of run (success or error)
- oerr  out  1  error flag; held until next accepted istart
- oerr_code  out  2  00 none, 01 CRC retries exhausted, 10 timeout
- oblk_idx  out  BLK_W  index of current block, 0-based

Behaviour:
- Reset values:
  - state S_IDLE
  - all outputs 0
  - counters 0
- All outputs registered.
- States:
  - S_IDLE
    - istart=1 and iblk_cnt≠0 → S_RCV_GO; latch count; clear oblk_idx, retry count, oerr, oerr_code.
    - istart=1 and iblk_cnt=0 → odone pulse next cycle; no error; stay S_IDLE.
  - S_RCV_GO
    - ostart_d=1 for exactly one cycle; clear armed flag and timeout → S_RCV_WAIT.
  - S_RCV_WAIT
    - Set armed when id_done=0.
    - armed and id_done=1 and id_crc_fail=0 → S_PROC_GO.
    - armed and id_done=1 and id_crc_fail=1:
      - retry < MAX_RETRY → retry+1, go S_RCV_GO.
      - otherwise → S_ERR, code 01.
  - S_PROC_GO
    - ostart_proc=1 for one cycle → S_PROC_WAIT.
  - S_PROC_WAIT
    - iproc_done=1 → S_SEND_GO.
  - S_SEND_GO
    - ostart_d=1 for one cycle; clear armed → S_SEND_WAIT.
    - The driver is parked waiting to send, so this pulse starts transmission.
  - S_SEND_WAIT
    - Set armed on id_done=0.
    - armed and id_done=1 (card busy released) → S_NEXT.
  - S_NEXT
    - oblk_idx = count-1 → S_FIN.
    - Otherwise oblk_idx+1, retry cleared → S_RCV_GO.
  - S_FIN
    - odone=1 for one cycle → S_IDLE.
  - S_ERR
    - oerr=1, odone=1 for one cycle → S_IDLE; oerr/oerr_code hold.
- Armed flag is required: id_done stays high for ≥1 cycle after ostart_d, until the driver registers the pulse.
- Timeout:
  - Counter runs in S_RCV_WAIT, S_PROC_WAIT, S_SEND_WAIT; clears on every state change.
  - Reaching all-ones → S_ERR, code 10; timeout takes priority over a same-cycle completion.
- istart while obusy=1: ignored, no effect on count.
- irst mid-run: next cycle S_IDLE, all outputs 0, no odone pulse.
- Retry counter width clog2(MAX_RETRY+1); never wraps. MAX_RETRY=0 → first CRC fail is an error.
- oblk_idx compare is unsigned against latched count-1; count 255 with BLK_W=8 runs idx 0..254.

Decomposition:
- Shared package sd_pkg holds:
  - state encoding localparams (4-bit, S_IDLE=0),
  - error code constants ERR_NONE/ERR_CRC/ERR_TMO,
  - MAX_RETRY default.
- One natural sub-module: wait_tmr (enable, clear, TMO_W counter, all-ones flag).
- Everything else stays in one always block plus the output register block.

Test Plan:
- 2-block run, driver model asserts id_done low 3 cycles after ostart_d and high 40 cycles later, iproc_done 10 cycles after ostart_proc:
  - ostart_d pulses = 4, ostart_proc pulses = 2, oblk_idx 0→1.
  - odone single pulse, oerr=0.
  - Check cycles: 4 driver jobs at 40 cycles each plus two 10-cycle processing waits.
- Block 0 with id_crc_fail on first 2 receives, MAX_RETRY=3:
  - 3 receive pulses for block 0, then proceeds.
  - oerr=0 at completion.
- id_crc_fail on 4 consecutive receives:
  - after 4th, S_ERR; oerr=1, oerr_code=01.
  - odone pulse; no ostart_proc ever issued.
- iproc_done never asserted, TMO_W=6:
  - 63 cycles after entering S_PROC_WAIT → oerr=1, oerr_code=10, odone pulse.
- iblk_cnt=0 → odone pulse 1 cycle later, no ostart_d, obusy stays 0.
- irst asserted mid S_SEND_WAIT:
  - next cycle all outputs 0, obusy=0.
  - A following istart with iblk_cnt=1 runs a clean 1-block transfer.
